// File: rtl/psram_init_seq_if.sv
// Handshake bundle between the PSRAM init sequencer and the serial command shifter.
`timescale 1ns/1ps
interface psram_init_seq_if;
  logic       reinit;
  logic       ready;
  logic [7:0] command;
  logic       strobe;
  logic       init_done;
  logic       qpi_mode;
  logic       error;

  modport master (
    input  reinit, ready,
    output command, strobe, init_done, qpi_mode, error
  );

  modport slave (
    output reinit, ready,
    input  command, strobe, init_done, qpi_mode, error
  );
endinterface

// File: rtl/psram_init_seq.sv
// PSRAM power-up sequencer: power-up wait, then RSTEN/RST[/QPI-enter] over the shifter handshake.
// Macro PSRAM_INIT_QPI_EN adds the 0x35 QPI-enter command and drives qpi_mode.
`timescale 1ns/1ps
module psram_init_seq #(
  parameter int POWERUP_CYCLES = 30000,
  parameter int GAP_CYCLES     = 4,
  parameter int BUSY_TIMEOUT   = 4
) (
  input logic              clk,
  input logic              rst,
  psram_init_seq_if.master bus
);

`ifdef PSRAM_INIT_QPI_EN
  localparam int NCMD = 3;
`else
  localparam int NCMD = 2;
`endif

  localparam int MAX_PG  = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_PG > BUSY_TIMEOUT) ? MAX_PG : BUSY_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PU_C  = CNT_W'(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] BT_C  = CNT_W'(BUSY_TIMEOUT);
  localparam logic [1:0]       LAST_IDX = 2'(NCMD - 1);

  typedef enum logic [2:0] {
    ST_POWERUP, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_GAP, ST_DONE, ST_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             qpi_q, qpi_d;
  logic             err_q, err_d;

  function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cmd_byte = 8'h66;
      2'd1:    cmd_byte = 8'h99;
      default: cmd_byte = 8'h35;
    endcase
  endfunction

  // Saturating so a long wait can never wrap back onto a compare value.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_POWERUP;
      cnt_q    <= '0;
      idx_q    <= '0;
      cmd_q    <= 8'h00;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      qpi_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      qpi_q    <= qpi_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_POWERUP:   if (cnt_q == PU_C) state_d = ST_ISSUE;
      ST_ISSUE:     if (bus.ready) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!bus.ready)           state_d = ST_WAIT_DONE;
        else if (cnt_inc == BT_C) state_d = ST_ERROR;
      end
      ST_WAIT_DONE: if (bus.ready) state_d = ST_GAP;
      ST_GAP:       if (cnt_q == GAP_C) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_ISSUE;
      ST_DONE,
      ST_ERROR:     if (bus.reinit) state_d = ST_ISSUE;
      default:      state_d = ST_POWERUP;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    strobe_d = 1'b0;
    done_d   = done_q;
    qpi_d    = qpi_q;
    err_d    = err_q;
    case (state_q)
      ST_POWERUP: cnt_d = (cnt_q == PU_C) ? '0 : cnt_inc;
      ST_ISSUE: begin
        if (bus.ready) begin
          cmd_d    = cmd_byte(idx_q);
          strobe_d = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (bus.ready && cnt_inc == BT_C) err_d = 1'b1;
      end
      ST_WAIT_DONE: if (bus.ready) cnt_d = '0;
      ST_GAP: begin
        if (cnt_q == GAP_C) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            done_d = 1'b1;
            qpi_d  = (cmd_q == 8'h35);
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        if (bus.reinit) begin
          done_d = 1'b0;
          qpi_d  = 1'b0;
          idx_d  = '0;
          cnt_d  = '0;
        end
      end
      ST_ERROR: begin
        if (bus.reinit) begin
          err_d = 1'b0;
          idx_d = '0;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.command   = cmd_q;
  assign bus.strobe    = strobe_q;
  assign bus.init_done = done_q;
  assign bus.error     = err_q;
`ifdef PSRAM_INIT_QPI_EN
  assign bus.qpi_mode  = qpi_q;
`else
  assign bus.qpi_mode  = 1'b0;
`endif

endmodule
